// File: rtl/core_l1_port_pkg.sv
// Shared types and default widths for the core-to-L1 load/store port.
package core_l1_port_pkg;

    // Lifecycle of one outstanding-table entry
    typedef enum logic [1:0] {
        ENT_FREE = 2'd0,
        ENT_PEND = 2'd1,
        ENT_DONE = 2'd2
    } ent_state_e;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int TAG_W_DEF  = 2;

endpackage

// File: rtl/core_l1_port.sv
// Core-side load/store port: tags ops to L1, tracks out-of-order responses, retires results in order.
// Optional counters stat_issued/stat_stall when CORE_L1_PORT_STATS_EN is defined.
//
// state    | meaning
// ENT_FREE | slot unused, may be allocated at tail
// ENT_PEND | request issued, waiting for L1 response
// ENT_DONE | response captured, waiting to retire at head
module core_l1_port
    import core_l1_port_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int TAG_W  = TAG_W_DEF,
    localparam int BE_W  = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              op_valid,
    output logic              op_ready,
    input  logic              op_we,
    input  logic [ADDR_W-1:0] op_addr,
    input  logic [DATA_W-1:0] op_wdata,
    input  logic [BE_W-1:0]   op_be,

    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_we,
    output logic [DATA_W-1:0] res_rdata,

    output logic              req_valid,
    input  logic              req_ready,
    output logic              req_we,
    output logic [ADDR_W-1:0] req_addr,
    output logic [DATA_W-1:0] req_wdata,
    output logic [BE_W-1:0]   req_be,
    output logic [TAG_W-1:0]  req_tag,

    input  logic              rsp_valid,
    input  logic [TAG_W-1:0]  rsp_tag,
    input  logic [DATA_W-1:0] rsp_rdata,

    output logic              err_unexp
`ifdef CORE_L1_PORT_STATS_EN
    ,
    output logic [31:0]       stat_issued,
    output logic [31:0]       stat_stall
`endif
);

    localparam int DEPTH = 2 ** TAG_W;
    localparam logic [TAG_W:0] DEPTH_CNT = (TAG_W + 1)'(DEPTH);

    ent_state_e        ent_state [DEPTH];
    logic              ent_we    [DEPTH];
    logic [DATA_W-1:0] ent_data  [DEPTH];

    logic [TAG_W-1:0]  head;
    logic [TAG_W-1:0]  tail;
    logic [TAG_W:0]    count;
    logic              run_q;

    logic              full;
    logic              issue;
    logic              retire;
    logic              rsp_hit;

    // run_q holds the handshakes low while reset is asserted and for the first edge after
    assign full      = (count == DEPTH_CNT);
    assign req_valid = run_q && op_valid && !full;
    assign op_ready  = run_q && req_ready && !full;
    assign req_we    = op_we;
    assign req_addr  = op_addr;
    assign req_wdata = op_wdata;
    assign req_be    = op_be;
    assign req_tag   = tail;

    assign res_valid = (ent_state[head] == ENT_DONE);
    assign res_we    = ent_we[head];
    assign res_rdata = ent_data[head];

    assign issue   = req_valid && req_ready;
    assign retire  = res_valid && res_ready;
    assign rsp_hit = rsp_valid && (ent_state[rsp_tag] == ENT_PEND);

    // Issue targets a FREE tail, retire a DONE head and a hit a PEND entry, so the three never collide
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_state[i] <= ENT_FREE;
                ent_we[i]    <= 1'b0;
                ent_data[i]  <= '0;
            end
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            run_q     <= 1'b0;
            err_unexp <= 1'b0;
        end else begin
            run_q <= 1'b1;
            if (issue) begin
                ent_state[tail] <= ENT_PEND;
                ent_we[tail]    <= op_we;
                tail            <= tail + 1'b1;
            end
            if (rsp_hit) begin
                ent_state[rsp_tag] <= ENT_DONE;
                ent_data[rsp_tag]  <= rsp_rdata;
            end
            if (rsp_valid && !rsp_hit) begin
                err_unexp <= 1'b1;
            end
            if (retire) begin
                ent_state[head] <= ENT_FREE;
                head            <= head + 1'b1;
            end
            case ({issue, retire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef CORE_L1_PORT_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_issued <= '0;
            stat_stall  <= '0;
        end else begin
            if (issue) begin
                stat_issued <= stat_issued + 32'd1;
            end
            if (op_valid && !op_ready) begin
                stat_stall <= stat_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/core_l1_port.md
CORE_L1_PORT -- requirements
Module: core_l1_port

Interface
REQ-001 SHALL have parameters (name, default, meaning): ADDR_W, 32, request address width.
REQ-002 SHALL have parameter DATA_W, 32, load/store data width; BE_W = DATA_W/8, derived.
REQ-003 SHALL have parameter TAG_W, 2, tag width; DEPTH = 2**TAG_W outstanding entries.
REQ-004 SHALL have ports (name, direction, width, meaning): clk, in, 1, sole clock; rst_n, in, 1, asynchronous active-low reset.
REQ-005 SHALL have core-side op ports: op_valid in 1; op_ready out 1; op_we in 1; op_addr in ADDR_W; op_wdata in DATA_W; op_be in BE_W.
REQ-006 SHALL have result ports: res_valid out 1; res_ready in 1; res_we out 1; res_rdata out DATA_W.
REQ-007 SHALL have L1 request ports (core-to-L1 initiator): req_valid out 1; req_ready in 1; req_we out 1; req_addr out ADDR_W; req_wdata out DATA_W; req_be out BE_W; req_tag out TAG_W.
REQ-008 SHALL have L1 response ports: rsp_valid in 1; rsp_tag in TAG_W; rsp_rdata in DATA_W; there is no backpressure on responses.
REQ-009 SHALL have status port err_unexp, out, 1, sticky flag for an unexpected response tag.

Function
REQ-010 SHALL keep a DEPTH-entry circular table, each entry in state FREE, PEND or DONE, with a head pointer, a tail pointer and an occupancy count of width TAG_W+1.
REQ-011 SHALL drive req_valid = op_valid && !full, op_ready = req_ready && !full, and pass op_we/addr/wdata/be straight through; req_tag SHALL equal the tail index (zero-latency issue).
REQ-012 SHALL, on a request handshake (req_valid && req_ready), mark the tail entry FREE->PEND, store op_we, and increment tail modulo DEPTH.
REQ-013 SHALL, on rsp_valid with the tagged entry PEND, store rsp_rdata and move the entry PEND->DONE; writes also wait for this acknowledgement.
REQ-014 SHALL, on rsp_valid with the tagged entry FREE or DONE, leave the table unchanged and set err_unexp to 1 until reset.
REQ-015 SHALL drive res_valid = (head entry DONE), and res_we/res_rdata from the head entry; the minimum response-to-result latency is 1 cycle.
REQ-016 SHALL, on a result handshake (res_valid && res_ready), move the head entry DONE->FREE and increment head modulo DEPTH; results retire strictly in issue order whatever the response order.
REQ-017 SHALL compute full from the registered count only, with no same-cycle bypass: when full, op_ready stays 0 even if a retire happens in that cycle.
REQ-018 SHALL allow issue, response and retire in the same cycle; count SHALL change by +1, -1 or 0 accordingly.
REQ-019 SHALL accept a response and a retire for different entries in the same cycle; a response cannot target the retiring head, because the head must already be DONE.
REQ-020 SHALL hold res_rdata/res_we stable while res_valid && !res_ready.

Reset
REQ-021 SHALL, while rst_n=0 (asynchronously), set all entries FREE, head=tail=count=0, err_unexp=0, res_valid=0, req_valid=0 and op_ready=0.
REQ-022 SHALL discard all outstanding entries on a reset mid-operation; responses that arrive after reset target FREE entries and set err_unexp per REQ-014.

Configuration
REQ-023 SHALL, when CORE_L1_PORT_STATS_EN is defined, add outputs stat_issued (32 bits, request handshakes) and stat_stall (32 bits, cycles with op_valid && !op_ready); both reset to 0 and wrap on overflow.
REQ-024 SHALL, without CORE_L1_PORT_STATS_EN, have neither the stat ports nor the counter logic.

Structure
REQ-025 SHALL place the entry-state enum (FREE/PEND/DONE) and the default width constants in shared package core_l1_port_pkg.
REQ-026 SHALL be a single module with no sub-modules; the entry table is flops, not an SRAM macro.

Verification
REQ-027 Single load to 0x100, L1 responds tag 0 with 0xDEADBEEF 3 cycles later -> res_valid 1 cycle after the response, res_rdata=0xDEADBEEF, res_we=0.
REQ-028 Four loads issued (tags 0-3), responses arrive in order 3,1,0,2 -> results retire in order tags 0,1,2,3 with matching data; the fifth op sees op_ready=0 until the first retire.
REQ-029 Full table, head DONE, res_ready=1 and op_valid=1 in the same cycle -> retire occurs, op_ready=0 that cycle, op_ready=1 the next cycle.
REQ-030 rsp_valid with tag 2 while entry 2 is FREE -> err_unexp=1 and stays 1; table contents and count unchanged.
REQ-031 Two loads outstanding, rst_n pulsed low -> all outputs at reset values, count=0; a later response for tag 0 sets err_unexp.
REQ-032 With CORE_L1_PORT_STATS_EN, 5 ops issued with req_ready=0 held for 3 cycles -> stat_issued=5, stat_stall=3.
